sr_flag_arbiter: RTL and testbench

Round-robin controller that shares a bank of NFLAGS set/reset flip-flops (one SR_FF per flag) between NREQ requesters. It grants one request at a time and converts its SET/CLEAR/TOGGLE operation into a one-cycle S or R pulse on the addressed flag. It never drives S and R high together on any bit, which keeps the flag bank out of its undefined state. It sits between the requesting blocks and the flag bank, and reads the bank's Q outputs back for TOGGLE.

---
 rtl/sr_flag_pkg.sv | 28 ++
 rtl/sr_flag_arbiter_if.sv | 40 ++++
 rtl/sr_flag_arbiter_rr_pick.sv | 30 +++
 rtl/sr_flag_arbiter.sv | 135 +++++++++++++
 tb/tb_sr_flag_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sr_flag_pkg.sv
// Shared encodings for the SR flag arbiter: requester op codes, FSM states,
// and the op-to-pulse mapping used when a grant is issued.
package sr_flag_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // Returns {s, r} for one flag; TOGGLE inverts the sampled flag value q.
    function automatic logic [1:0] op_to_sr(input logic [1:0] op, input logic q);
        logic [1:0] sr;
        sr = 2'b00;
        unique case (op)
            OP_SET:  sr = 2'b10;
            OP_CLR:  sr = 2'b01;
            OP_TGL:  sr = q ? 2'b01 : 2'b10;
            default: sr = 2'b00;
        endcase
        return sr;
    endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side handshake bundle of the SR flag arbiter: request level, op and
// index per requester, bank-wide clear request, and the completion pulses.
interface sr_flag_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NFLAGS = 8
);
    localparam int unsigned IW = $clog2(NFLAGS);

    logic [NREQ-1:0]    REQ;
    logic [2*NREQ-1:0]  OP;
    logic [IW*NREQ-1:0] IDX;
    logic               CLR_ALL;
    logic [NREQ-1:0]    ACK;
    logic               ALL_ACK;
    logic               ERR;
    logic               BUSY;

    modport master (
        output REQ,
        output OP,
        output IDX,
        output CLR_ALL,
        input  ACK,
        input  ALL_ACK,
        input  ERR,
        input  BUSY
    );

    modport slave (
        input  REQ,
        input  OP,
        input  IDX,
        input  CLR_ALL,
        output ACK,
        output ALL_ACK,
        output ERR,
        output BUSY
    );

endinterface

// File: rtl/sr_flag_arbiter_rr_pick.sv
// Combinational round-robin first-set finder: searches req_i from ptr_i upward,
// wrapping modulo N, and reports the first set index.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] gnt_o,
    output logic                 vld_o
);

    localparam int unsigned PW = $clog2(N);

    int unsigned idx;

    // Walk offsets high to low so the smallest offset from ptr_i wins last.
    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % N;
            if (req_i[idx]) begin
                gnt_o = PW'(idx);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that turns SET/CLEAR/TOGGLE requests into one-cycle S or R
// pulses on an external SR flip-flop bank, with a bank-wide clear path.
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NFLAGS = 8
) (
    input  logic               CLK,
    input  logic               CLR,
    sr_flag_arbiter_if.slave   bus,
    input  logic [NFLAGS-1:0]  Q_IN,
    output logic [NFLAGS-1:0]  S_OUT,
    output logic [NFLAGS-1:0]  R_OUT
);

    localparam int unsigned IW = $clog2(NFLAGS);
    localparam int unsigned PW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [NFLAGS-1:0] s_q, s_d;
    logic [NFLAGS-1:0] r_q, r_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              all_ack_q, all_ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [PW-1:0]     pick_gnt;
    logic              pick_vld;
    logic [1:0]        op_g;
    logic [IW-1:0]     idx_g;
    logic [1:0]        sr_g;

    rr_pick #(
        .N (NREQ)
    ) u_rr_pick (
        .req_i (bus.REQ),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .vld_o (pick_vld)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        s_d       = '0;
        r_d       = '0;
        ack_d     = '0;
        all_ack_d = 1'b0;
        err_d     = 1'b0;
        busy_d    = 1'b0;
        op_g      = bus.OP[2*int'(pick_gnt) +: 2];
        idx_g     = bus.IDX[IW*int'(pick_gnt) +: IW];
        sr_g      = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.CLR_ALL) begin
                    r_d       = '1;
                    all_ack_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_DRIVE;
                end else if (pick_vld) begin
                    gnt_d           = pick_gnt;
                    ack_d[pick_gnt] = 1'b1;
                    busy_d          = 1'b1;
                    state_d         = ST_DRIVE;
                    if (int'(idx_g) >= int'(NFLAGS)) begin
                        err_d = 1'b1;
                    end else begin
                        // Loop select keeps every bank index in range for any NFLAGS.
                        for (int f = 0; f < int'(NFLAGS); f++) begin
                            if (int'(idx_g) == f) begin
                                sr_g   = op_to_sr(op_g, Q_IN[f]);
                                s_d[f] = sr_g[1];
                                r_d[f] = sr_g[0];
                            end
                        end
                    end
                end
            end
            ST_DRIVE: begin
                state_d = ST_IDLE;
                if (!all_ack_q) begin
                    if (int'(gnt_q) == int'(NREQ) - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            s_q       <= '0;
            r_q       <= '0;
            ack_q     <= '0;
            all_ack_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            s_q       <= s_d;
            r_q       <= r_d;
            ack_q     <= ack_d;
            all_ack_q <= all_ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign S_OUT       = s_q;
    assign R_OUT       = r_q;
    assign bus.ACK     = ack_q;
    assign bus.ALL_ACK = all_ack_q;
    assign bus.ERR     = err_q;
    assign bus.BUSY    = busy_q;

    // The bank has an undefined state for S=R=1; never allow it.
    a_no_sr_overlap: assert property (@(posedge CLK) (s_q & r_q) == '0);
    a_ack_onehot:    assert property (@(posedge CLK) $onehot0(ack_q));
    a_ack_excl:      assert property (@(posedge CLK) !(all_ack_q && (ack_q != '0)));

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: an 8-flag instance driving a behavioural SR
// bank, plus a 6-flag instance used for out-of-range index handling.
module tb_sr_flag_arbiter;
    import sr_flag_pkg::*;

    logic       CLK;
    logic       CLR;
    logic [7:0] s8, r8, q8;
    logic [5:0] s6, r6, q6;

    int n_checks;
    int n_errors;

    sr_flag_arbiter_if #(.NREQ(4), .NFLAGS(8)) bus8 ();
    sr_flag_arbiter_if #(.NREQ(4), .NFLAGS(6)) bus6 ();

    sr_flag_arbiter #(.NREQ(4), .NFLAGS(8)) dut8 (
        .CLK   (CLK),
        .CLR   (CLR),
        .bus   (bus8),
        .Q_IN  (q8),
        .S_OUT (s8),
        .R_OUT (r8)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAGS(6)) dut6 (
        .CLK   (CLK),
        .CLR   (CLR),
        .bus   (bus6),
        .Q_IN  (q6),
        .S_OUT (s6),
        .R_OUT (r6)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural SR flag banks, sampling on the falling edge.
    always @(negedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (s8[i])      q8[i] <= 1'b1;
            else if (r8[i]) q8[i] <= 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            if (s6[i])      q6[i] <= 1'b1;
            else if (r6[i]) q6[i] <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Invariants checked mid-cycle on the 8-flag instance.
    always @(negedge CLK) begin
        if (!CLR && $time > 20) begin
            check("s_r_overlap", 32'(s8 & r8), 32'h0);
            check("ack_exclusive",
                  32'($onehot0(bus8.ACK) && !(bus8.ALL_ACK && (bus8.ACK != '0))), 32'h1);
        end
    end

    // Request r with op/idx from IDLE; check the DRIVE cycle and the bank afterwards.
    task automatic issue(input string tag, input int r, input logic [1:0] op, input int idx,
                         input logic [7:0] exp_s, input logic [7:0] exp_r,
                         input logic [7:0] exp_q);
        logic [2:0] idx3;
        idx3 = 3'(idx);
        bus8.OP[2*r +: 2]  = op;
        bus8.IDX[3*r +: 3] = idx3;
        bus8.REQ[r]        = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(bus8.ACK), 32'(1 << r));
        check({tag, "_s"}, 32'(s8), 32'(exp_s));
        check({tag, "_r"}, 32'(r8), 32'(exp_r));
        check({tag, "_busy"}, 32'(bus8.BUSY), 32'h1);
        bus8.REQ[r] = 1'b0;
        tick();
        check({tag, "_ack_clr"}, 32'(bus8.ACK), 32'h0);
        check({tag, "_q"}, 32'(q8), 32'(exp_q));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        q8           = 8'h00;
        q6           = 6'h00;
        CLR          = 1'b1;
        bus8.REQ     = '0;
        bus8.OP      = '0;
        bus8.IDX     = '0;
        bus8.CLR_ALL = 1'b0;
        bus6.REQ     = '0;
        bus6.OP      = '0;
        bus6.IDX     = '0;
        bus6.CLR_ALL = 1'b0;
        tick();
        tick();
        check("rst_s", 32'(s8), 32'h0);
        check("rst_r", 32'(r8), 32'h0);
        check("rst_ack", 32'(bus8.ACK), 32'h0);
        check("rst_all_ack", 32'(bus8.ALL_ACK), 32'h0);
        check("rst_err", 32'(bus8.ERR), 32'h0);
        check("rst_busy", 32'(bus8.BUSY), 32'h0);
        CLR = 1'b0;
        tick();
        check("idle_busy", 32'(bus8.BUSY), 32'h0);

        issue("set3", 0, OP_SET, 3, 8'h08, 8'h00, 8'h08);
        issue("tgl3a", 1, OP_TGL, 3, 8'h00, 8'h08, 8'h00);
        issue("tgl3b", 1, OP_TGL, 3, 8'h08, 8'h00, 8'h08);

        // Round-robin with all four requesting continuously from rr_ptr=0.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus8.OP[2*i +: 2]  = OP_SET;
            bus8.IDX[3*i +: 3] = 3'(i + 4);
        end
        bus8.REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_ack", 32'(bus8.ACK), 32'(1 << (k % 4)));
            check("rr_s", 32'(s8), 32'(1 << ((k % 4) + 4)));
            if (k == 4) bus8.REQ = 4'b0000;
            tick();
            check("rr_gap", 32'(bus8.ACK), 32'h0);
        end
        check("rr_q", 32'(q8), 32'hF8);

        // CLR_ALL wins over a simultaneous request.
        bus8.OP[5:4]  = OP_SET;
        bus8.IDX[8:6] = 3'd5;
        bus8.REQ      = 4'b0100;
        bus8.CLR_ALL  = 1'b1;
        tick();
        check("clrall_r", 32'(r8), 32'hFF);
        check("clrall_s", 32'(s8), 32'h00);
        check("clrall_allack", 32'(bus8.ALL_ACK), 32'h1);
        check("clrall_ack", 32'(bus8.ACK), 32'h0);
        bus8.CLR_ALL = 1'b0;
        tick();
        check("clrall_q", 32'(q8), 32'h00);
        check("clrall_allack_clr", 32'(bus8.ALL_ACK), 32'h0);
        tick();
        check("after_clrall_ack", 32'(bus8.ACK), 32'h4);
        check("after_clrall_s", 32'(s8), 32'h20);
        bus8.REQ = 4'b0000;
        tick();
        check("after_clrall_q", 32'(q8), 32'h20);

        // Reset during DRIVE aborts and returns rr_ptr to 0.
        bus8.OP[3:2]  = OP_SET;
        bus8.IDX[5:3] = 3'd0;
        bus8.OP[7:6]  = OP_NOP;
        bus8.REQ      = 4'b0010;
        tick();
        check("abort_pre_ack", 32'(bus8.ACK), 32'h2);
        CLR      = 1'b1;
        bus8.REQ = 4'b1010;
        tick();
        check("abort_ack", 32'(bus8.ACK), 32'h0);
        check("abort_s", 32'(s8), 32'h0);
        check("abort_busy", 32'(bus8.BUSY), 32'h0);
        CLR = 1'b0;
        tick();
        check("regrant_ack", 32'(bus8.ACK), 32'h2);
        check("regrant_s", 32'(s8), 32'h01);
        bus8.REQ = 4'b1000;
        tick();
        tick();
        check("nop_ack", 32'(bus8.ACK), 32'h8);
        check("nop_sr", 32'(s8 | r8), 32'h0);
        bus8.REQ = 4'b0000;
        tick();
        check("abort_q", 32'(q8), 32'h21);

        // Out-of-range index on the 6-flag instance.
        bus6.OP[1:0]  = OP_SET;
        bus6.IDX[2:0] = 3'd7;
        bus6.REQ      = 4'b0001;
        tick();
        check("oor_ack", 32'(bus6.ACK), 32'h1);
        check("oor_err", 32'(bus6.ERR), 32'h1);
        check("oor_s", 32'(s6), 32'h0);
        check("oor_r", 32'(r6), 32'h0);
        bus6.REQ = 4'b0000;
        tick();
        check("oor_err_clr", 32'(bus6.ERR), 32'h0);
        bus6.IDX[2:0] = 3'd5;
        bus6.REQ      = 4'b0001;
        tick();
        check("inrange_err", 32'(bus6.ERR), 32'h0);
        check("inrange_s", 32'(s6), 32'h20);
        bus6.REQ = 4'b0000;
        tick();
        check("inrange_q", 32'(q6), 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
